// File: rtl/stack_mem_ctrl.sv
// Stack sequencer: turns PUSH/POP/PEEK requests into data-memory
// accesses and single-cycle SP strobes for the register file.
module stack_mem_ctrl #(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] STACK_TOP   = 16'hFFFF,
  parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hFF00,
  parameter int                RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] sp,
  input  logic [DATA_W-1:0] dm_rd_data,
  output logic              push,
  output logic              pop,
  output logic [DATA_W-1:0] dm_addr,
  output logic              dm_wr_en,
  output logic [DATA_W-1:0] dm_wr_data,
  output logic              dm_rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WRITE, SPINC, READ, WAIT, DONE, ERR
  } state_t;

  state_t     state;
  logic [2:0] cnt;

  // The register file only shows the bumped SP in READ, so the read
  // address is always formed as the SP seen on the entering edge plus one.
  logic [DATA_W-1:0] sp_next;
  assign sp_next = sp + DATA_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      push       <= 1'b0;
      pop        <= 1'b0;
      dm_addr    <= '0;
      dm_wr_en   <= 1'b0;
      dm_wr_data <= '0;
      dm_rd_en   <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      push       <= 1'b0;
      pop        <= 1'b0;
      dm_addr    <= '0;
      dm_wr_en   <= 1'b0;
      dm_wr_data <= '0;
      dm_rd_en   <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            busy <= 1'b1;
            unique case (op)
              OP_PUSH: begin
                if (sp == STACK_LIMIT) begin
                  state    <= ERR;
                  done     <= 1'b1;
                  overflow <= 1'b1;
                end else begin
                  state      <= WRITE;
                  dm_addr    <= sp;
                  dm_wr_data <= wr_data;
                  dm_wr_en   <= 1'b1;
                  push       <= 1'b1;
                end
              end
              OP_POP: begin
                if (sp == STACK_TOP) begin
                  state     <= ERR;
                  done      <= 1'b1;
                  underflow <= 1'b1;
                end else begin
                  state <= SPINC;
                  pop   <= 1'b1;
                end
              end
              OP_PEEK: begin
                if (sp == STACK_TOP) begin
                  state     <= ERR;
                  done      <= 1'b1;
                  underflow <= 1'b1;
                end else begin
                  state    <= READ;
                  dm_addr  <= sp_next;
                  dm_rd_en <= 1'b1;
                end
              end
              default: begin
                state <= DONE;
                done  <= 1'b1;
              end
            endcase
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        SPINC: begin
          state    <= READ;
          dm_addr  <= sp_next;
          dm_rd_en <= 1'b1;
        end
        READ: begin
          state   <= WAIT;
          cnt     <= 3'(RD_LAT);
          dm_addr <= dm_addr;
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            rd_data <= dm_rd_data;
            state   <= DONE;
            done    <= 1'b1;
          end else begin
            cnt     <= cnt - 3'd1;
            dm_addr <= dm_addr;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl: unit 0 uses RD_LAT=1, unit 1 RD_LAT=3,
// each with its own register-file SP model and data memory model.
module tb_stack_mem_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req        [2];
  logic [1:0]  op         [2];
  logic [15:0] wr_data    [2];
  logic [15:0] sp         [2];
  logic [15:0] dm_rd_data [2];
  logic        push       [2];
  logic        pop        [2];
  logic [15:0] dm_addr    [2];
  logic        dm_wr_en   [2];
  logic [15:0] dm_wr_data [2];
  logic        dm_rd_en   [2];
  logic [15:0] rd_data    [2];
  logic        busy       [2];
  logic        done       [2];
  logic        overflow   [2];
  logic        underflow  [2];

  logic        ld     [2];
  logic [15:0] ld_val [2];
  logic [15:0] mem  [2][256];
  logic [15:0] pipe [2][4];

  for (genvar g = 0; g < 2; g++) begin : u
    stack_mem_ctrl #(
      .DATA_W(16), .STACK_TOP(16'hFFFF), .STACK_LIMIT(16'hFF00),
      .RD_LAT(g == 0 ? 1 : 3)
    ) dut (
      .clk(clk), .reset(reset), .req(req[g]), .op(op[g]),
      .wr_data(wr_data[g]), .sp(sp[g]), .dm_rd_data(dm_rd_data[g]),
      .push(push[g]), .pop(pop[g]), .dm_addr(dm_addr[g]),
      .dm_wr_en(dm_wr_en[g]), .dm_wr_data(dm_wr_data[g]),
      .dm_rd_en(dm_rd_en[g]), .rd_data(rd_data[g]), .busy(busy[g]),
      .done(done[g]), .overflow(overflow[g]), .underflow(underflow[g])
    );
  end

  // Register-file SP and data memory with an RD_LAT-deep read pipe.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ld[g]) sp[g] <= ld_val[g];
      else if (push[g]) sp[g] <= sp[g] - 16'd1;
      else if (pop[g]) sp[g] <= sp[g] + 16'd1;
      if (dm_wr_en[g]) mem[g][dm_addr[g][7:0]] <= dm_wr_data[g];
      pipe[g][0] <= dm_rd_en[g] ? mem[g][dm_addr[g][7:0]] : 16'hDEAD;
      for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
    end
  end
  assign dm_rd_data[0] = pipe[0][0];
  assign dm_rd_data[1] = pipe[1][2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          lat, n_push, n_pop, n_wr, n_rd, n_both, n_nobusy;
  logic        ov, uf;
  logic [15:0] wr_addr, wr_dat, rd_addr;

  task automatic load_sp(input int g, input logic [15:0] v);
    @(negedge clk); ld[g] = 1'b1; ld_val[g] = v;
    @(negedge clk); ld[g] = 1'b0;
  endtask

  // Issue one request and trace it up to its done cycle (bounded).
  task automatic do_op(input int g, input logic [1:0] o,
                       input logic [15:0] d);
    @(negedge clk); req[g] = 1'b1; op[g] = o; wr_data[g] = d;
    @(negedge clk); req[g] = 1'b0;
    lat = -1; n_push = 0; n_pop = 0; n_wr = 0; n_rd = 0;
    n_both = 0; n_nobusy = 0; ov = 1'b0; uf = 1'b0;
    wr_addr = '0; wr_dat = '0; rd_addr = '0;
    for (int c = 1; c <= 20; c++) begin
      if (push[g]) n_push++;
      if (pop[g]) n_pop++;
      if (dm_wr_en[g]) begin
        n_wr++; wr_addr = dm_addr[g]; wr_dat = dm_wr_data[g];
      end
      if (dm_rd_en[g]) begin n_rd++; rd_addr = dm_addr[g]; end
      if ((push[g] && pop[g]) || (dm_wr_en[g] && dm_rd_en[g])) n_both++;
      if (!busy[g]) n_nobusy++;
      if (done[g]) begin
        lat = c; ov = overflow[g]; uf = underflow[g];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic post_idle(input int g, input string tag);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy[g]), 0);
    check({tag, "_idle_addr"}, 32'(dm_addr[g]), 0);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      req[g] = 0; op[g] = 0; wr_data[g] = 0; ld[g] = 0; ld_val[g] = 0;
    end
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_busy", 32'(busy[0]), 0);
    check("rst_done", 32'(done[0]), 0);
    check("rst_addr", 32'(dm_addr[0]), 0);
    check("rst_rd_data", 32'(rd_data[0]), 0);
    check("rst_strobes", {28'd0, push[0], pop[0], dm_wr_en[0], dm_rd_en[0]}, 0);
    reset = 1'b0;

    // PUSH at empty stack
    load_sp(0, 16'hFFFF);
    do_op(0, 2'b00, 16'h1234);
    check("push_lat", 32'(lat), 2);
    check("push_nwr", 32'(n_wr), 1);
    check("push_npush", 32'(n_push), 1);
    check("push_npop", 32'(n_pop), 0);
    check("push_addr", 32'(wr_addr), 32'hFFFF);
    check("push_data", 32'(wr_dat), 32'h1234);
    check("push_busy", 32'(n_nobusy), 0);
    post_idle(0, "push");
    check("push_sp", 32'(sp[0]), 32'hFFFE);

    // POP, RD_LAT=1
    do_op(0, 2'b01, 16'h0);
    check("pop_lat", 32'(lat), 4);
    check("pop_npop", 32'(n_pop), 1);
    check("pop_npush", 32'(n_push), 0);
    check("pop_nrd", 32'(n_rd), 1);
    check("pop_addr", 32'(rd_addr), 32'hFFFF);
    check("pop_rd_data", 32'(rd_data[0]), 32'h1234);
    check("pop_excl", 32'(n_both), 0);
    post_idle(0, "pop");
    check("pop_sp", 32'(sp[0]), 32'hFFFF);

    // Underflow, overflow, reserved op
    do_op(0, 2'b01, 16'h0);
    check("uf_lat", 32'(lat), 1);
    check("uf_flags", {30'd0, ov, uf}, 1);
    check("uf_acc", 32'(n_pop + n_rd), 0);
    do_op(0, 2'b10, 16'h0);
    check("uf_peek_flags", {30'd0, ov, uf}, 1);
    check("uf_peek_rd", 32'(n_rd), 0);
    load_sp(0, 16'hFF00);
    do_op(0, 2'b00, 16'h5555);
    check("ov_lat", 32'(lat), 1);
    check("ov_flags", {30'd0, ov, uf}, 2);
    check("ov_acc", 32'(n_wr + n_push), 0);
    check("ov_sp", 32'(sp[0]), 32'hFF00);
    do_op(0, 2'b11, 16'h0);
    check("nop_lat", 32'(lat), 1);
    check("nop_flags", {30'd0, ov, uf}, 0);
    check("nop_acc", 32'(n_wr + n_rd + n_push + n_pop), 0);

    // Last legal push
    load_sp(0, 16'hFF01);
    do_op(0, 2'b00, 16'h0BEE);
    check("lim_lat", 32'(lat), 2);
    check("lim_addr", 32'(wr_addr), 32'hFF01);
    post_idle(0, "lim");
    check("lim_sp", 32'(sp[0]), 32'hFF00);

    // RD_LAT=3: PEEK then POP
    load_sp(1, 16'hFFFF);
    do_op(1, 2'b00, 16'h1234);
    check("l3_push_lat", 32'(lat), 2);
    do_op(1, 2'b10, 16'h0);
    check("peek_lat", 32'(lat), 5);
    check("peek_npop", 32'(n_pop), 0);
    check("peek_addr", 32'(rd_addr), 32'hFFFF);
    check("peek_rd_data", 32'(rd_data[1]), 32'h1234);
    post_idle(1, "peek");
    check("peek_sp", 32'(sp[1]), 32'hFFFE);
    do_op(1, 2'b01, 16'h0);
    check("l3_pop_lat", 32'(lat), 6);
    check("l3_pop_addr", 32'(rd_addr), 32'hFFFF);
    check("l3_pop_rd_data", 32'(rd_data[1]), 32'h1234);

    // req held high during PUSH
    load_sp(0, 16'hFFFF);
    @(negedge clk); req[0] = 1'b1; op[0] = 2'b00; wr_data[0] = 16'hAAAA;
    @(negedge clk);
    check("hold_c1", {29'd0, busy[0], push[0], done[0]}, 3'b110);
    @(negedge clk);
    check("hold_c2", {29'd0, busy[0], push[0], done[0]}, 3'b101);
    @(negedge clk);
    check("hold_c3", {29'd0, busy[0], push[0], done[0]}, 3'b000);
    @(negedge clk);
    check("hold_c4", {29'd0, busy[0], push[0], done[0]}, 3'b110);
    req[0] = 1'b0;
    @(negedge clk);
    check("hold_c5", {29'd0, busy[0], push[0], done[0]}, 3'b101);
    @(negedge clk);
    check("hold_c6", {29'd0, busy[0], push[0], done[0]}, 3'b000);
    check("hold_sp", 32'(sp[0]), 32'hFFFD);

    // Reset in WAIT of a POP
    load_sp(0, 16'hFFFE);
    @(negedge clk); req[0] = 1'b1; op[0] = 2'b01;
    @(negedge clk); req[0] = 1'b0;
    check("ab_spinc", 32'(pop[0]), 1);
    @(negedge clk);
    check("ab_read", 32'(dm_rd_en[0]), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ab_strobes", {28'd0, push[0], pop[0], dm_wr_en[0], dm_rd_en[0]}, 0);
    check("ab_addr", 32'(dm_addr[0]), 0);
    check("ab_busy_done", {30'd0, busy[0], done[0]}, 0);
    check("ab_rd_data", 32'(rd_data[0]), 0);
    @(negedge clk); reset = 1'b0;
    n_pop = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pop[0] || done[0]) n_pop++;
    end
    check("ab_no_pop", 32'(n_pop), 0);
    check("ab_sp", 32'(sp[0]), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
